// File: rtl/stream_pkt_arbiter_if.sv
// Bundle of per-source request streams, the shared output stream and status.
// Ports: s_data_i/s_last_i/s_valid_i/en_i in, s_ready_o out (per source);
//        m_data_o/m_last_o/m_valid_o/m_id_o/busy_o out, m_ready_i in (shared).
interface stream_pkt_arbiter_if #(
  parameter int T_DATA_WIDTH = 4,
  parameter int N_SOURCES    = 4
);
  localparam int ID_W = (N_SOURCES > 1) ? $clog2(N_SOURCES) : 1;

  logic [T_DATA_WIDTH-1:0] s_data_i [N_SOURCES];
  logic [N_SOURCES-1:0]    s_last_i;
  logic [N_SOURCES-1:0]    s_valid_i;
  logic [N_SOURCES-1:0]    s_ready_o;
  logic [N_SOURCES-1:0]    en_i;
  logic [T_DATA_WIDTH-1:0] m_data_o;
  logic                    m_last_o;
  logic                    m_valid_o;
  logic                    m_ready_i;
  logic [ID_W-1:0]         m_id_o;
  logic                    busy_o;

  // Arbiter side.
  modport slave (
    input  s_data_i, s_last_i, s_valid_i, en_i, m_ready_i,
    output s_ready_o, m_data_o, m_last_o, m_valid_o, m_id_o, busy_o
  );

  // Environment side: sources, upsizer and enable control.
  modport master (
    output s_data_i, s_last_i, s_valid_i, en_i, m_ready_i,
    input  s_ready_o, m_data_o, m_last_o, m_valid_o, m_id_o, busy_o
  );
endinterface

// File: rtl/stream_pkt_arbiter.sv
// Purpose: round-robin packet arbiter merging N_SOURCES streams onto one stream.
// Latency: one IDLE arbitration cycle per packet; beats pass through combinationally.
// Backpressure: m_ready_i routed only to the granted source; low m_ready_i holds everything.
// Ports: clk, rst_n (async active-low), bus (stream_pkt_arbiter_if.slave).
module stream_pkt_arbiter #(
  parameter int T_DATA_WIDTH = 4,
  parameter int N_SOURCES    = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  stream_pkt_arbiter_if.slave bus
);
  localparam int ID_W = (N_SOURCES > 1) ? $clog2(N_SOURCES) : 1;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t               state;
  logic [ID_W-1:0]      grant;
  logic [ID_W-1:0]      rr_ptr;
  logic                 busy_q;

  logic [N_SOURCES-1:0] req;
  logic                 found;
  logic [ID_W-1:0]      pick;
  logic [ID_W-1:0]      nxt_ptr;
  logic                 last_xfer;

  // Round-robin search: first requester at or after rr_ptr, wrapping modulo N.
  always_comb begin
    req   = bus.s_valid_i & bus.en_i;
    found = 1'b0;
    pick  = rr_ptr;
    for (int i = 0; i < N_SOURCES; i++) begin
      logic [ID_W-1:0] idx;
      idx = ID_W'((int'(rr_ptr) + i) % N_SOURCES);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign nxt_ptr   = (grant == ID_W'(N_SOURCES - 1)) ? '0 : grant + 1'b1;
  assign last_xfer = bus.s_valid_i[grant] & bus.m_ready_i & bus.s_last_i[grant];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state  <= LOCKED;
            grant  <= pick;
            busy_q <= 1'b1;
          end
        end
        LOCKED: begin
          // Grant is held until the last beat moves; en_i and valid drops are ignored.
          if (last_xfer) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            rr_ptr <= nxt_ptr;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Data path is a pure mux on the registered grant; nothing is driven while IDLE.
  // m_id_o keeps showing the previous grant in IDLE.
  assign bus.m_data_o  = (state == LOCKED) ? bus.s_data_i[grant] : '0;
  assign bus.m_last_o  = (state == LOCKED) & bus.s_last_i[grant];
  assign bus.m_valid_o = (state == LOCKED) & bus.s_valid_i[grant];
  assign bus.s_ready_o = (state == LOCKED)
                         ? ((N_SOURCES'(1) << grant) & {N_SOURCES{bus.m_ready_i}})
                         : '0;
  assign bus.m_id_o    = grant;
  assign bus.busy_o    = busy_q;
endmodule

// File: tb/tb_stream_pkt_arbiter.sv
// Directed bench for stream_pkt_arbiter with N_SOURCES=4, T_DATA_WIDTH=4.
// Inputs change 1 time unit after the rising edge; outputs are checked before the next edge.
// Expected values are hand-derived constants per scenario.
module tb_stream_pkt_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  stream_pkt_arbiter_if #(.T_DATA_WIDTH(4), .N_SOURCES(4)) bus ();

  stream_pkt_arbiter #(.T_DATA_WIDTH(4), .N_SOURCES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data_default();
    for (int i = 0; i < 4; i++) bus.s_data_i[i] = 4'(8 + i);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.s_valid_i = '0;
    bus.s_last_i  = '0;
    bus.en_i      = 4'hF;
    bus.m_ready_i = 1'b1;
    set_data_default();
    tick();
    check("rst_m_valid", 32'(bus.m_valid_o), 32'd0);
    check("rst_busy",    32'(bus.busy_o),    32'd0);
    check("rst_s_ready", 32'(bus.s_ready_o), 32'd0);
    check("rst_m_id",    32'(bus.m_id_o),    32'd0);
    tick();
    rst_n = 1'b1;
  endtask

  // Two-beat packet: IDLE bubble, beat 0, beat 1 (last) -> three cycles.
  task automatic pkt2(input int exp_id);
    bus.s_last_i = 4'h0;
    #1;
    check("p2_bubble_busy",  32'(bus.busy_o),    32'd0);
    check("p2_bubble_valid", 32'(bus.m_valid_o), 32'd0);
    tick();
    check("p2_id",      32'(bus.m_id_o),    32'(exp_id));
    check("p2_busy",    32'(bus.busy_o),    32'd1);
    check("p2_data",    32'(bus.m_data_o),  32'(8 + exp_id));
    check("p2_s_ready", 32'(bus.s_ready_o), 32'(1 << exp_id));
    tick();
    bus.s_last_i = 4'hF;
    #1;
    check("p2_last",    32'(bus.m_last_o), 32'd1);
    check("p2_id_b1",   32'(bus.m_id_o),   32'(exp_id));
    tick();
  endtask

  // Single-beat packet: IDLE bubble then one LOCKED cycle.
  task automatic pkt1(input int exp_id);
    #1;
    check("p1_bubble_busy", 32'(bus.busy_o), 32'd0);
    tick();
    check("p1_id",    32'(bus.m_id_o),    32'(exp_id));
    check("p1_last",  32'(bus.m_last_o),  32'd1);
    check("p1_valid", 32'(bus.m_valid_o), 32'd1);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int order032 [5];
    int order034 [4];
    order032 = '{0, 1, 2, 3, 0};
    order034 = '{0, 1, 3, 0};

    // First grant after reset: sources 1 and 3 request, pointer at 0 -> 1 wins.
    do_reset();
    bus.s_valid_i = 4'b1010;
    bus.s_last_i  = 4'hF;
    #1;
    check("g1_pre_busy", 32'(bus.busy_o), 32'd0);
    tick();
    check("g1_busy",    32'(bus.busy_o),    32'd1);
    check("g1_id",      32'(bus.m_id_o),    32'd1);
    check("g1_valid",   32'(bus.m_valid_o), 32'd1);
    check("g1_s_ready", 32'(bus.s_ready_o), 32'b0010);
    tick();
    check("g1_idle_busy",  32'(bus.busy_o),    32'd0);
    check("g1_idle_id",    32'(bus.m_id_o),    32'd1);
    check("g1_idle_ready", 32'(bus.s_ready_o), 32'd0);
    tick();
    check("g1_next_id", 32'(bus.m_id_o), 32'd3);
    tick();
    bus.s_valid_i = '0;

    // All sources sending 2-beat packets: strict rotation 0,1,2,3,0.
    do_reset();
    bus.s_valid_i = 4'hF;
    foreach (order032[k]) pkt2(order032[k]);

    // Source 2 masked off: rotation skips it.
    do_reset();
    bus.en_i      = 4'b1011;
    bus.s_valid_i = 4'hF;
    bus.s_last_i  = 4'hF;
    foreach (order034[k]) pkt1(order034[k]);

    // Lone single-beat requester: one transfer every two cycles.
    do_reset();
    bus.s_valid_i = 4'b0010;
    bus.s_last_i  = 4'hF;
    for (int k = 0; k < 3; k++) pkt1(1);

    // Backpressure mid-packet on source 2 while source 0 waits.
    do_reset();
    bus.s_valid_i   = 4'b0100;
    bus.s_data_i[2] = 4'hA;
    tick();
    check("bp_id",      32'(bus.m_id_o),    32'd2);
    check("bp_data_a",  32'(bus.m_data_o),  32'hA);
    bus.s_valid_i = 4'b0101;
    #1;
    check("bp_ready_a", 32'(bus.s_ready_o), 32'b0100);
    tick();
    bus.s_data_i[2] = 4'hB;
    bus.m_ready_i   = 1'b0;
    bus.en_i        = 4'h0;
    #1;
    check("bp_data_b",   32'(bus.m_data_o),  32'hB);
    check("bp_ready_lo", 32'(bus.s_ready_o), 32'd0);
    check("bp_valid_b",  32'(bus.m_valid_o), 32'd1);
    tick();
    check("bp_hold_busy", 32'(bus.busy_o),   32'd1);
    check("bp_hold_id",   32'(bus.m_id_o),   32'd2);
    check("bp_hold_data", 32'(bus.m_data_o), 32'hB);
    bus.m_ready_i = 1'b1;
    #1;
    check("bp_ready_b", 32'(bus.s_ready_o), 32'b0100);
    tick();
    bus.s_data_i[2] = 4'hC;
    bus.s_last_i    = 4'b0100;
    bus.en_i        = 4'hF;
    #1;
    check("bp_last_c", 32'(bus.m_last_o),  32'd1);
    check("bp_data_c", 32'(bus.m_data_o),  32'hC);
    check("bp_src0_c", 32'(bus.s_ready_o[0]), 32'd0);
    tick();
    check("bp_idle_busy",  32'(bus.busy_o),    32'd0);
    check("bp_idle_ready", 32'(bus.s_ready_o), 32'd0);
    tick();
    check("bp_next_id",    32'(bus.m_id_o),    32'd0);
    check("bp_next_ready", 32'(bus.s_ready_o), 32'b0001);
    set_data_default();

    // Asynchronous reset during beat 2 of a packet from source 3.
    do_reset();
    bus.s_valid_i = 4'b1000;
    tick();
    check("ar_id", 32'(bus.m_id_o), 32'd3);
    tick();
    bus.s_valid_i = 4'hF;
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(bus.m_valid_o), 32'd0);
    check("ar_busy",  32'(bus.busy_o),    32'd0);
    check("ar_id0",   32'(bus.m_id_o),    32'd0);
    check("ar_ready", 32'(bus.s_ready_o), 32'd0);
    #1;
    rst_n = 1'b1;
    tick();
    check("ar_regrant_id",   32'(bus.m_id_o), 32'd0);
    check("ar_regrant_busy", 32'(bus.busy_o), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
